tv_recorder: RTL and testbench

Synthesizable test-vector recorder: samples a packed stimulus/response word from a unit under test each accepted cycle, buffers it in an internal FIFO, and streams records out on a valid/ready port for off-chip dump as a `.tv` file. It is the writer side of the team's vector flow, whose benches read `.tv` files with `$readmemb`. It sits beside any module under bring-up on the FPGA, with `sample_data` wired to `{inputs, outputs}` in test-vector order. A run ends with one trailer word carrying the record and drop counts.

---
 rtl/tv_recorder.sv | 127 ++++++++++++
 tb/tb_tv_recorder.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tv_recorder.sv
// Test-vector recorder: captures sample words into a FIFO and streams them out, ending each run with a {drops, records} trailer.
// Optional macro TV_RECORDER_STALL_EN: backpressure the source when the FIFO is full instead of dropping samples.
module tv_recorder #(
  parameter int TV_WIDTH    = 96,
  parameter int DEPTH       = 16,
  parameter int MAX_RECORDS = 100
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                stop,
  input  logic                sample_valid,
  output logic                sample_ready,
  input  logic [TV_WIDTH-1:0] sample_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [TV_WIDTH-1:0] out_data,
  output logic                out_last,
  output logic                busy,
  output logic [15:0]         records,
  output logic                overflow
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {IDLE, CAPTURE, DRAIN, TRAILER, DONE} state_t;

  state_t              state, stateNext;
  logic [TV_WIDTH-1:0] mem [DEPTH];
  logic [AW:0]         wrPtr, rdPtr;
  logic [15:0]         recCnt, dropCnt;
  logic                ovf;
  logic                full, empty, fifoOut, capturing;
  logic                doWrite, doRead, doDrop, launch, hitMax;

  function automatic logic [15:0] satInc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [TV_WIDTH-1:0] trailerWord(input logic [15:0] rec,
                                                      input logic [15:0] drop);
    logic [TV_WIDTH-1:0] w;
    w        = '0;
    w[15:0]  = rec;
    w[31:16] = drop;
    return w;
  endfunction

  assign full      = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
  assign empty     = (wrPtr == rdPtr);
  assign capturing = (state == CAPTURE);
  assign fifoOut   = ((state == CAPTURE) || (state == DRAIN)) && !empty;
  assign doRead    = fifoOut && out_ready;
  assign launch    = start && ((state == IDLE) || (state == DONE));

`ifdef TV_RECORDER_STALL_EN
  assign sample_ready = capturing && !full;
  assign doWrite      = sample_valid && sample_ready;
  assign doDrop       = 1'b0;
`else
  // A full FIFO still takes the sample when the head leaves in the same cycle.
  assign sample_ready = capturing;
  assign doWrite      = sample_valid && capturing && (!full || doRead);
  assign doDrop       = sample_valid && capturing && full && !doRead;
`endif

  assign hitMax = doWrite && (recCnt == 16'(MAX_RECORDS - 1));

  always_comb begin
    stateNext = state;
    case (state)
      IDLE, DONE: if (start) stateNext = CAPTURE;
      CAPTURE:    if (stop || hitMax) stateNext = DRAIN;
      DRAIN:      if (empty) stateNext = TRAILER;
      TRAILER:    if (out_ready) stateNext = DONE;
      default:    stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      wrPtr   <= '0;
      rdPtr   <= '0;
      recCnt  <= '0;
      dropCnt <= '0;
      ovf     <= 1'b0;
    end else begin
      state <= stateNext;
      if (launch) begin
        wrPtr   <= '0;
        rdPtr   <= '0;
        recCnt  <= '0;
        dropCnt <= '0;
        ovf     <= 1'b0;
      end else begin
        if (doWrite) begin
          wrPtr  <= wrPtr + (AW+1)'(1);
          recCnt <= recCnt + 16'd1;
        end
        if (doRead) rdPtr <= rdPtr + (AW+1)'(1);
        if (doDrop) begin
          dropCnt <= satInc16(dropCnt);
          ovf     <= 1'b1;
        end
      end
    end
  end

  // Storage carries no reset; its contents are only visible through fifoOut.
  always_ff @(posedge clk) begin
    if (doWrite) mem[wrPtr[AW-1:0]] <= sample_data;
  end

  always_comb begin
    out_data = '0;
    if (state == TRAILER)  out_data = trailerWord(recCnt, dropCnt);
    else if (fifoOut)      out_data = mem[rdPtr[AW-1:0]];
  end

  assign out_valid = fifoOut || (state == TRAILER);
  assign out_last  = (state == TRAILER);
  assign busy      = (state == CAPTURE) || (state == DRAIN) || (state == TRAILER);
  assign records   = recCnt;
  assign overflow  = ovf;

endmodule

// File: tb/tb_tv_recorder.sv
// Bench for tv_recorder: scenario table plus random runs, checked against a queue-based model of the recorder's rules.
module tb_tv_recorder;

  localparam int TV_WIDTH    = 96;
  localparam int DEPTH       = 16;
  localparam int MAX_RECORDS = 100;
`ifdef TV_RECORDER_STALL_EN
  localparam bit STALL = 1'b1;
`else
  localparam bit STALL = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                start = 1'b0, stop = 1'b0;
  logic                sample_valid = 1'b0;
  logic                sample_ready;
  logic [TV_WIDTH-1:0] sample_data = '0;
  logic                out_valid, out_last, busy, overflow;
  logic                out_ready = 1'b0;
  logic [TV_WIDTH-1:0] out_data;
  logic [15:0]         records;

  tv_recorder #(.TV_WIDTH(TV_WIDTH), .DEPTH(DEPTH), .MAX_RECORDS(MAX_RECORDS)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .sample_valid(sample_valid), .sample_ready(sample_ready), .sample_data(sample_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .records(records), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: phase 0 = idle/done, 1 = capturing, 2 = draining or trailer.
  int                  phase = 0;
  int                  mRec = 0, mDrop = 0;
  logic [TV_WIDTH-1:0] expQ[$];
  bit                  trailerSeen = 0;
  logic [TV_WIDTH-1:0] lastTrailer = '0;
  int                  dataBeats = 0;

  function automatic logic [TV_WIDTH-1:0] expTrailer();
    logic [TV_WIDTH-1:0] w;
    int d;
    d = (mDrop > 65535) ? 65535 : mDrop;
    w = '0;
    w[15:0]  = 16'(mRec);
    w[31:16] = 16'(d);
    return w;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      phase = 0; mRec = 0; mDrop = 0; expQ.delete();
    end else begin
      bit launchNow, expReady, rd;
      launchNow = start && (phase == 0);
      expReady  = (phase == 1) && (STALL ? (expQ.size() < DEPTH) : 1'b1);
      chk("busy", busy, phase != 0);
      chk("records", records, 16'(mRec));
      chk("overflow", overflow, mDrop > 0);
      chk("sampleReady", sample_ready, expReady);
      if (phase == 0) chk("outValidIdle", out_valid, 1'b0);
      if (phase == 1) chk("outValidCapture", out_valid, expQ.size() > 0);
      if (phase != 0 && expQ.size() > 0) chk("outLastWithData", out_last, 1'b0);
      if (out_valid && !out_last) begin
        if (expQ.size() == 0) chk("spuriousBeat", 1'b1, 1'b0);
        else chk("outData", out_data, expQ[0]);
      end
      if (out_valid && out_last) begin
        chk("trailerWord", out_data, expTrailer());
        chk("trailerPhase", phase, 2);
      end
      rd = (phase != 0) && (expQ.size() > 0) && out_ready;
      if (rd) dataBeats++;
      if (phase == 1 && sample_valid && expReady) begin
        if (expQ.size() < DEPTH || rd) begin
          expQ.push_back(sample_data);
          mRec++;
          if (mRec == MAX_RECORDS) phase = 2;
        end else begin
          mDrop++;
        end
      end
      if (rd) void'(expQ.pop_front());
      if (phase == 1 && stop) phase = 2;
      if (out_valid && out_last && out_ready) begin
        trailerSeen = 1;
        lastTrailer = out_data;
        phase = 0;
      end
      if (launchNow) begin
        phase = 1; mRec = 0; mDrop = 0; expQ.delete(); dataBeats = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulseStart();
    trailerSeen = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic waitTrailer(input string name);
    for (int k = 0; k < 3000 && !trailerSeen; k++) tick();
    chk({name, ".trailerSeen"}, trailerSeen, 1'b1);
  endtask

  typedef struct {
    string name;
    int    n;
    int    hold;      // cycles with out_ready low at the start of the run
    int    stopMode;  // 0 none, 1 stop after samples, 2 stop with last sample
    int    expRec;
    int    expDrop;
  } vec_t;

  vec_t vecs[5];

  task automatic runVec(input vec_t v);
    int cyc, i, idle;
    bit acc;
    pulseStart();
    cyc = 0; i = 0; idle = 0;
    while (i < v.n && idle < 60) begin
      out_ready    = (cyc >= v.hold);
      sample_valid = 1'b1;
      sample_data  = TV_WIDTH'(i + 1);
      stop         = (v.stopMode == 2) && (i == v.n - 1);
      @(negedge clk);
      acc = sample_ready;
      tick();
      cyc++;
      if (acc) begin i++; idle = 0; end else idle++;
    end
    sample_valid = 1'b0;
    stop = 1'b0;
    while (cyc < v.hold) begin
      out_ready = 1'b0;
      tick();
      cyc++;
    end
    out_ready = 1'b1;
    if (v.stopMode == 1) begin
      stop = 1'b1;
      tick();
      stop = 1'b0;
    end
    waitTrailer(v.name);
    tick();
    chk({v.name, ".recCount"}, lastTrailer[15:0], 16'(v.expRec));
    chk({v.name, ".dropCount"}, lastTrailer[31:16], 16'(v.expDrop));
    chk({v.name, ".trailerUpper"}, lastTrailer[TV_WIDTH-1:32], '0);
    chk({v.name, ".delivered"}, dataBeats, v.expRec);
    chk({v.name, ".overflow"}, overflow, v.expDrop > 0);
    chk({v.name, ".busyDone"}, busy, 1'b0);
  endtask

  task automatic randomRun(input int idx);
    int stopAt;
    bit holdReq;
    holdReq = 0;
    stopAt = $urandom_range(100, 250);
    pulseStart();
    for (int c = 0; c < 300; c++) begin
      if (!holdReq) begin
        sample_valid = ($urandom_range(0, 9) < 7);
        sample_data  = {$urandom, $urandom, $urandom};
      end
      out_ready = ($urandom_range(0, 3) != 0);
      stop      = (c == stopAt);
      @(negedge clk);
      holdReq = sample_valid && !sample_ready;
      tick();
    end
    sample_valid = 1'b0;
    stop = 1'b0;
    out_ready = 1'b1;
    waitTrailer($sformatf("random%0d", idx));
    tick();
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{"basic", 5, 0, 1, 5, 0};
    vecs[1] = '{"stopWithLast", 3, 0, 2, 3, 0};
    vecs[2] = '{"emptyRun", 0, 0, 1, 0, 0};
    vecs[3] = '{"autoStop", 110, 0, 0, MAX_RECORDS, 0};
    vecs[4] = '{"backpressure", 20, 40, 1, STALL ? 20 : 16, STALL ? 0 : 4};

    repeat (3) @(posedge clk);
    #1;
    chk("reset.sampleReady", sample_ready, 1'b0);
    chk("reset.outValid", out_valid, 1'b0);
    chk("reset.outData", out_data, '0);
    chk("reset.outLast", out_last, 1'b0);
    chk("reset.busy", busy, 1'b0);
    chk("reset.records", records, 16'd0);
    chk("reset.overflow", overflow, 1'b0);
    rst = 1'b0;
    tick();

    for (int k = 0; k < 5; k++) runVec(vecs[k]);

    // start while draining must not restart the run
    pulseStart();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      sample_valid = 1'b1;
      sample_data  = TV_WIDTH'(32'hA0 + k);
      tick();
    end
    sample_valid = 1'b0;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("drainStart.records", records, 16'd3);
    chk("drainStart.busy", busy, 1'b1);
    out_ready = 1'b1;
    waitTrailer("drainStart");
    tick();
    chk("drainStart.recCount", lastTrailer[15:0], 16'd3);
    chk("drainStart.delivered", dataBeats, 3);

    // reset with 8 records buffered, then a clean run
    pulseStart();
    out_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      sample_valid = 1'b1;
      sample_data  = TV_WIDTH'(32'hBEEF0 + k);
      tick();
    end
    sample_valid = 1'b0;
    chk("midRun.records", records, 16'd8);
    rst = 1'b1;
    #1;
    chk("midRst.outValid", out_valid, 1'b0);
    chk("midRst.outData", out_data, '0);
    chk("midRst.outLast", out_last, 1'b0);
    chk("midRst.records", records, 16'd0);
    chk("midRst.busy", busy, 1'b0);
    chk("midRst.overflow", overflow, 1'b0);
    chk("midRst.sampleReady", sample_ready, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    runVec(vecs[0]);

    for (int r = 0; r < 3; r++) randomRun(r);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
